// File: rtl/byte_lane_mem_ctrl.sv
// rtl/byte_lane_mem_ctrl.sv - four-lane byte RAM access controller; MISALIGN_SPLIT_EN splits word-crossing accesses
module byte_lane_mem_ctrl #(
    parameter int AW    = 10,
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_uns,
    input  logic [AW+1:0]       req_addr,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic                resp_err,
    output logic [LANES*AW-1:0] lane_addr,
    output logic [8*LANES-1:0]  lane_d,
    output logic [LANES-1:0]    lane_we,
    output logic [LANES-1:0]    lane_sel,
    input  logic [8*LANES-1:0]  lane_q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
`ifdef MISALIGN_SPLIT_EN
        S_ACC1 = 2'd2,
`endif
        S_RESP = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic [31:0]   r_rbuf;

    logic [2:0]    w_req_n;
    logic          w_req_err;
    logic [2:0]    w_n;
    logic [AW-1:0] w_word;
    logic [1:0]    w_off;
    logic          w_use;
    logic [31:0]   w_cap;
    logic          w_accept;

    function automatic logic [2:0] size_to_n(input logic [1:0] s);
        case (s)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    assign w_req_n  = size_to_n(req_size);
    assign w_n      = size_to_n(r_size);
    assign w_word   = r_addr[AW+1:2];
    assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef MISALIGN_SPLIT_EN
    logic [2:0]    w_sum;
    logic          w_cross;
    logic [AW-1:0] w_word1;

    assign w_sum     = {1'b0, r_addr[1:0]} + w_n;
    assign w_cross   = (w_sum > 3'd4);
    // Natural AW-bit overflow wraps the top word back to word 0.
    assign w_word1   = w_word + 1'b1;
    assign w_req_err = (req_size == 2'b11);
`else
    logic [2:0] w_req_sum;

    assign w_req_sum = {1'b0, req_addr[1:0]} + w_req_n;
    assign w_req_err = (req_size == 2'b11) || (w_req_sum > 3'd4);
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_next = w_req_err ? S_RESP : S_ACC0;
                end
            end
            S_ACC0: begin
`ifdef MISALIGN_SPLIT_EN
                w_state_next = w_cross ? S_ACC1 : S_RESP;
`else
                w_state_next = S_RESP;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            S_ACC1: w_state_next = S_RESP;
`endif
            S_RESP: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Lane i carries access byte (i - lane0) mod 4; ACC0 owns lanes at or above
    // the start lane, ACC1 owns the wrapped-around lanes in the next word.
    always_comb begin
        lane_sel  = '0;
        lane_we   = '0;
        lane_d    = '0;
        lane_addr = '0;
        w_cap     = r_rbuf;
        w_off     = '0;
        w_use     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_off = 2'(i) - r_addr[1:0];
            w_use = 1'b0;
            lane_addr[i*AW +: AW] = w_word;
            if ({1'b0, w_off} < w_n) begin
                if (r_state == S_ACC0 && 2'(i) >= r_addr[1:0]) begin
                    w_use = 1'b1;
                end
`ifdef MISALIGN_SPLIT_EN
                if (r_state == S_ACC1 && 2'(i) < r_addr[1:0]) begin
                    w_use = 1'b1;
                    lane_addr[i*AW +: AW] = w_word1;
                end
`endif
            end
            if (w_use) begin
                lane_sel[i]        = 1'b1;
                lane_we[i]         = r_we;
                lane_d[8*i +: 8]   = r_wdata[{w_off, 3'b000} +: 8];
                w_cap[{w_off, 3'b000} +: 8] = lane_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        resp_rdata = '0;
        if (r_state == S_RESP && !r_err && !r_we) begin
            case (r_size)
                2'b00:   resp_rdata = {{24{~r_uns & r_rbuf[7]}}, r_rbuf[7:0]};
                2'b01:   resp_rdata = {{16{~r_uns & r_rbuf[15]}}, r_rbuf[15:0]};
                2'b10:   resp_rdata = r_rbuf;
                default: resp_rdata = '0;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = (r_state == S_RESP) && r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rbuf  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_uns   <= req_uns;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= w_req_err;
                r_rbuf  <= '0;
            end
`ifdef MISALIGN_SPLIT_EN
            if (r_state == S_ACC0 || r_state == S_ACC1) begin
`else
            if (r_state == S_ACC0) begin
`endif
                r_rbuf <= w_cap;
            end
        end
    end

endmodule

// File: tb/tb_byte_lane_mem_ctrl.sv
// tb/tb_byte_lane_mem_ctrl.sv - vector-table bench for byte_lane_mem_ctrl with a four-bank byte RAM model
module tb_byte_lane_mem_ctrl;
    localparam int AW = 10;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_uns;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [4*AW-1:0] lane_addr;
    logic [31:0]   lane_d;
    logic [3:0]    lane_we;
    logic [3:0]    lane_sel;
    logic [31:0]   lane_q;

    byte_lane_mem_ctrl #(.AW(AW), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .lane_addr(lane_addr), .lane_d(lane_d),
        .lane_we(lane_we), .lane_sel(lane_sel), .lane_q(lane_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [4][1024];
    logic       clr;
    int         we_cyc;
    int         sel_cyc;

    always_comb begin
        lane_q = '0;
        for (int l = 0; l < 4; l++) lane_q[8*l +: 8] = mem[l][lane_addr[l*AW +: AW]];
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int l = 0; l < 4; l++)
                for (int a = 0; a < 1024; a++) mem[l][a] <= 8'h00;
        end else begin
            for (int l = 0; l < 4; l++)
                if (lane_we[l]) mem[l][lane_addr[l*AW +: AW]] <= lane_d[8*l +: 8];
        end
        if (|lane_we)  we_cyc  <= we_cyc + 1;
        if (|lane_sel) sel_cyc <= sel_cyc + 1;
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wc;
        int          sc;
    } vec_t;

    vec_t vecs[32];
    int   nvec;
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic add_vec(input logic we, input logic [1:0] size, input logic uns,
                           input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic err,
                           input int lat, input int wc, input int sc);
        vecs[nvec].we = we;       vecs[nvec].size = size;   vecs[nvec].uns = uns;
        vecs[nvec].addr = addr;   vecs[nvec].wdata = wdata; vecs[nvec].rdata = rdata;
        vecs[nvec].err = err;     vecs[nvec].lat = lat;     vecs[nvec].wc = wc;
        vecs[nvec].sc = sc;
        nvec++;
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic do_req(input vec_t v, output logic [31:0] rd, output logic er, output int lat);
        wait_ready();
        req_we = v.we; req_size = v.size; req_uns = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        lat = 99; rd = '0; er = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},  {31'b0, req_ready},  32'd1);
        check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, " resp_err"},   {31'b0, resp_err},   32'd0);
        check({tag, " resp_rdata"}, resp_rdata,          32'd0);
        check({tag, " lane_we"},    {28'b0, lane_we},    32'd0);
        check({tag, " lane_sel"},   {28'b0, lane_sel},   32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          wc0;
        int          sc0;
        int          resp_cnt;
        vec_t        v;

        n_pass = 0; n_total = 0; nvec = 0;
        rst_n = 1'b0; clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_uns = 1'b0;
        req_addr = '0; req_wdata = '0;

        //      we    size   uns   addr     wdata         rdata         err  lat wc sc
        add_vec(1'b1, 2'b10, 1'b0, 12'h010, 32'h11223344, 32'h00000000, 1'b0, 2, 1, 1);
        add_vec(1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'h11223344, 1'b0, 2, 0, 1);
        add_vec(1'b1, 2'b00, 1'b0, 12'h023, 32'h00000080, 32'h00000000, 1'b0, 2, 1, 1);
        add_vec(1'b0, 2'b00, 1'b0, 12'h023, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 1);
        add_vec(1'b0, 2'b00, 1'b1, 12'h023, 32'h0,        32'h00000080, 1'b0, 2, 0, 1);
        add_vec(1'b0, 2'b01, 1'b0, 12'h022, 32'h0,        32'hFFFF8000, 1'b0, 2, 0, 1);
        add_vec(1'b1, 2'b01, 1'b0, 12'h031, 32'h00001234, 32'h00000000, 1'b0, 2, 1, 1);
        add_vec(1'b0, 2'b01, 1'b0, 12'h031, 32'h0,        32'h00001234, 1'b0, 2, 0, 1);
        add_vec(1'b0, 2'b01, 1'b1, 12'h012, 32'h0,        32'h00001122, 1'b0, 2, 0, 1);
        add_vec(1'b0, 2'b11, 1'b0, 12'h010, 32'h0,        32'h00000000, 1'b1, 1, 0, 0);
        add_vec(1'b1, 2'b11, 1'b0, 12'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0, 0);
        add_vec(1'b0, 2'b10, 1'b1, 12'h010, 32'h0,        32'h11223344, 1'b0, 2, 0, 1);
`ifdef MISALIGN_SPLIT_EN
        add_vec(1'b1, 2'b01, 1'b0, 12'h007, 32'h0000BEEF, 32'h00000000, 1'b0, 3, 2, 2);
        add_vec(1'b0, 2'b01, 1'b0, 12'h007, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 0, 2);
        add_vec(1'b1, 2'b10, 1'b0, 12'hFFE, 32'hA1B2C3D4, 32'h00000000, 1'b0, 3, 2, 2);
        add_vec(1'b0, 2'b10, 1'b0, 12'hFFE, 32'h0,        32'hA1B2C3D4, 1'b0, 3, 0, 2);
        add_vec(1'b0, 2'b00, 1'b1, 12'h000, 32'h0,        32'h000000B2, 1'b0, 2, 0, 1);
        add_vec(1'b0, 2'b01, 1'b0, 12'hFFF, 32'h0,        32'hFFFFB2C3, 1'b0, 3, 0, 2);
`else
        add_vec(1'b1, 2'b10, 1'b0, 12'h005, 32'hCAFEBABE, 32'h00000000, 1'b1, 1, 0, 0);
        add_vec(1'b0, 2'b01, 1'b0, 12'h003, 32'h0,        32'h00000000, 1'b1, 1, 0, 0);
        add_vec(1'b0, 2'b00, 1'b1, 12'h005, 32'h0,        32'h00000000, 1'b0, 2, 0, 1);
        add_vec(1'b0, 2'b10, 1'b0, 12'h004, 32'h0,        32'h00000000, 1'b0, 2, 0, 1);
`endif

        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; clr = 1'b0;
        check_reset_outputs("post-reset");

        for (int i = 0; i < nvec; i++) begin
            v = vecs[i];
            wc0 = we_cyc; sc0 = sel_cyc;
            do_req(v, rd, er, lat);
            check($sformatf("v%0d rdata", i), rd, v.rdata);
            check($sformatf("v%0d err", i), {31'b0, er}, {31'b0, v.err});
            check($sformatf("v%0d latency", i), lat, v.lat);
            check($sformatf("v%0d we cycles", i), we_cyc - wc0, v.wc);
            check($sformatf("v%0d sel cycles", i), sel_cyc - sc0, v.sc);
        end

        check("word4 lane0", {24'b0, mem[0][4]}, 32'h44);
        check("word4 lane1", {24'b0, mem[1][4]}, 32'h33);
        check("word4 lane2", {24'b0, mem[2][4]}, 32'h22);
        check("word4 lane3", {24'b0, mem[3][4]}, 32'h11);
`ifdef MISALIGN_SPLIT_EN
        check("split lo word1 lane3", {24'b0, mem[3][1]}, 32'hEF);
        check("split hi word2 lane0", {24'b0, mem[0][2]}, 32'hBE);
        check("wrap word1023 lane2", {24'b0, mem[2][1023]}, 32'hD4);
        check("wrap word1023 lane3", {24'b0, mem[3][1023]}, 32'hC3);
        check("wrap word0 lane0", {24'b0, mem[0][0]}, 32'hB2);
        check("wrap word0 lane1", {24'b0, mem[1][0]}, 32'hA1);
`else
        check("rejected store word1 lane1", {24'b0, mem[1][1]}, 32'h00);
        check("rejected store word2 lane0", {24'b0, mem[0][2]}, 32'h00);
`endif

        // Abort an access mid-flight with an asynchronous reset.
        wait_ready();
`ifdef MISALIGN_SPLIT_EN
        req_we = 1'b1; req_size = 2'b10; req_uns = 1'b0;
        req_addr = 12'h00D; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort acc0 sel", {28'b0, lane_sel}, 32'hE);
        @(posedge clk); #1;
        check("abort acc1 sel", {28'b0, lane_sel}, 32'h1);
`else
        req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0;
        req_addr = 12'h010; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort acc0 sel", {28'b0, lane_sel}, 32'hF);
`endif
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        resp_cnt = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (resp_valid) resp_cnt++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) resp_cnt++;
        end
        check("abort no response", resp_cnt, 0);
`ifdef MISALIGN_SPLIT_EN
        check("abort word3 lane1", {24'b0, mem[1][3]}, 32'hEF);
        check("abort word3 lane3", {24'b0, mem[3][3]}, 32'hAD);
        check("abort word4 lane0 kept", {24'b0, mem[0][4]}, 32'h44);
`endif

        v.we = 1'b0; v.size = 2'b10; v.uns = 1'b0; v.addr = 12'h010; v.wdata = 32'h0;
        do_req(v, rd, er, lat);
        check("after abort rdata", rd, 32'h11223344);
        check("after abort latency", lat, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: actual running required finished");
        $fatal(1, "timeout");
    end
endmodule
